// File: rtl/mirror_checker.sv
// mirror_checker: checks that the low half of a 2N-bit vector equals the high half.
// Pair k is bit k against bit N+k. CHUNK pairs are compared per cycle over
// K = ceil(N/CHUNK) cycles. The result reports whether every pair matches and
// the lowest mismatching index.
// Optional build macro: MIRROR_CHECKER_EARLY_EXIT_EN -- when defined, the
// compare phase ends right after the chunk holding the first mismatch.
module mirror_checker #(
    parameter int N     = 10,
    parameter int CHUNK = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2*N-1:0]                 in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] mismatch_idx
);

    localparam int K  = (N + CHUNK - 1) / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*N-1:0]  data_q, data_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            found_q, found_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            out_q, out_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    // Per-pair difference, zero-padded so a partial last chunk never reports.
    logic [K*CHUNK-1:0] diff_pad_s;
    logic               chunk_hit_s;
    logic [IW-1:0]      chunk_idx_s;
    logic               last_chunk_s;
    logic               finish_s;

    // Lowest mismatching pair within the chunk selected by the counter.
    always_comb begin
        diff_pad_s          = '0;
        diff_pad_s[N-1:0]   = data_q[N-1:0] ^ data_q[2*N-1:N];
        chunk_hit_s         = 1'b0;
        chunk_idx_s         = '0;
        for (int c = 0; c < K; c++) begin
            // Walk downwards so the lowest set pair is the last one written.
            for (int j = CHUNK - 1; j >= 0; j--) begin
                chunk_hit_s = ((cnt_q == CW'(c)) && diff_pad_s[c*CHUNK+j]) ? 1'b1 : chunk_hit_s;
                chunk_idx_s = ((cnt_q == CW'(c)) && diff_pad_s[c*CHUNK+j]) ? IW'(c*CHUNK+j) : chunk_idx_s;
            end
        end
        last_chunk_s = (cnt_q == CW'(K - 1));
`ifdef MIRROR_CHECKER_EARLY_EXIT_EN
        finish_s = last_chunk_s | chunk_hit_s;
`else
        finish_s = last_chunk_s;
`endif
    end

    // Next-state, datapath update and registered-output precomputation.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        idx_d   = idx_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    idx_d   = '0;
                    out_d   = 1'b0;
                    state_d = S_CMP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMP: begin
                // Only the first mismatch found is recorded.
                if (chunk_hit_s && !found_q) begin
                    found_d = 1'b1;
                    idx_d   = chunk_idx_s;
                end else begin
                    found_d = found_q;
                end
                if (finish_s) begin
                    out_d   = ~(found_q | chunk_hit_s);
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            idx_q       <= '0;
            out_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            found_q     <= found_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out          = out_q;
    assign mismatch_idx = idx_q;

endmodule

// File: tb/tb_mirror_checker.sv
// Bench for mirror_checker: N=10/CHUNK=4 instance driven from a vector table
// with a scoreboard, plus an N=1/CHUNK=1 instance and reset/backpressure cases.
module tb_mirror_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_a;
    logic [19:0] in_data;
    logic [3:0]  idx_a;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out;
    logic [1:0]  b_in_data;
    logic [0:0]  b_idx;

    mirror_checker #(.N(10), .CHUNK(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out_a), .mismatch_idx(idx_a)
    );

    mirror_checker #(.N(1), .CHUNK(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out(b_out), .mismatch_idx(b_idx)
    );

`ifdef MIRROR_CHECKER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [19:0] data;
        logic        eo;
        logic [3:0]  ei;
        int          el;
        int          hold;
    } vec_t;

    typedef struct {
        logic       eo;
        logic [3:0] ei;
        int         el;
        int         t;
    } exp_t;

    vec_t  tbl [10];
    exp_t  sb [$];
    exp_t  mon_e;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    logic  prev_ov = 1'b0;
    logic [19:0] base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected latency for N=10, CHUNK=4: K+1=4, or first-mismatch chunk + 2 with early exit.
    function automatic int exp_lat(input logic eo, input int idx);
        if (EARLY && !eo) return idx / 4 + 2;
        return 4;
    endfunction

    // Scoreboard monitor: pop and compare on every new result of dut_a.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: out_valid rose with nothing pending (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("out", {31'd0, out_a}, {31'd0, mon_e.eo});
                check("mismatch_idx", {28'd0, idx_a}, {28'd0, mon_e.ei});
                check("latency", cyc - mon_e.t, mon_e.el);
            end
        end
        prev_ov = out_valid;
    end

    task automatic apply(input vec_t v);
        exp_t e;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = v.data;
        e.eo = v.eo; e.ei = v.ei; e.el = v.el; e.t = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~v.data;
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) break;
            @(negedge clk);
            in_data = 20'($urandom);
        end
        check("result_seen", {31'd0, out_valid}, 32'd1);
        if (out_valid !== 1'b1) sb.delete();
        for (int h = 0; h < v.hold; h++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_out", {31'd0, out_a}, {31'd0, v.eo});
            check("hold_idx", {28'd0, idx_a}, {28'd0, v.ei});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            in_valid = 1'b1;
            in_data  = 20'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_b(input logic [1:0] d, input logic eo);
        int t;
        int i;
        check("b_in_ready", {31'd0, b_in_ready}, 32'd1);
        b_in_valid = 1'b1;
        b_in_data  = d;
        t = cyc;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_data  = ~d;
        for (i = 0; i < 10; i++) begin
            if (b_out_valid === 1'b1) break;
            @(negedge clk);
        end
        check("b_result_seen", {31'd0, b_out_valid}, 32'd1);
        check("b_latency", cyc - t, 32'd2);
        check("b_out", {31'd0, b_out}, {31'd0, eo});
        check("b_idx", {31'd0, b_idx}, 32'd0);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check("b_release", {31'd0, b_out_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 20'd0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 2'd0; b_out_ready = 1'b0;
        base = {10'h32D, 10'h32D};

        tbl[0] = '{base,                                   1'b1, 4'd0, exp_lat(1'b1, 0), 5};
        tbl[1] = '{base ^ (20'd1 << 6) ^ (20'd1 << 12),    1'b0, 4'd2, exp_lat(1'b0, 2), 1};
        tbl[2] = '{base ^ (20'd1 << 9),                    1'b0, 4'd9, exp_lat(1'b0, 9), 0};
        tbl[3] = '{20'h00000,                              1'b1, 4'd0, exp_lat(1'b1, 0), 0};
        tbl[4] = '{20'hFFFFF,                              1'b1, 4'd0, exp_lat(1'b1, 0), 0};
        tbl[5] = '{base ^ (20'd1 << 15),                   1'b0, 4'd5, exp_lat(1'b0, 5), 2};
        tbl[6] = '{20'h003FF,                              1'b0, 4'd0, exp_lat(1'b0, 0), 0};
        tbl[7] = '{base ^ (20'd1 << 18) ^ (20'd1 << 8),    1'b1, 4'd0, exp_lat(1'b1, 0), 0};
        tbl[8] = '{20'h80100,                              1'b0, 4'd8, exp_lat(1'b0, 8), 0};
        tbl[9] = '{base ^ (20'd1 << 3) ^ (20'd1 << 14),    1'b0, 4'd3, exp_lat(1'b0, 3), 0};

        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", {31'd0, out_a}, 32'd0);
        check("rst_idx", {28'd0, idx_a}, 32'd0);
        check("rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);

        // First vector offered in the very first cycle out of reset.
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) apply(tbl[k]);

        // Reset during the second compare cycle discards the operation.
        in_valid = 1'b1;
        in_data  = base ^ (20'd1 << 9);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("midrst_no_result", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        apply(tbl[1]);

        // Single-pair instance.
        run_b(2'b10, 1'b0);
        run_b(2'b11, 1'b1);
        run_b(2'b01, 1'b0);
        run_b(2'b00, 1'b1);

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
